relobi_cut: RTL and testbench

RELOBI_CUT -- requirements
Module: relobi_cut

---
 rtl/relobi_cut.sv | 181 ++++++++++++++++++
 tb/tb_relobi_cut.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/relobi_cut.sv
// TMR-protected OBI register cut: one 2-entry buffer per channel with
// triplicated, majority-voted control state. Optional saturating fault
// counter enabled by defining RELOBI_CUT_FAULT_CNT_EN.

module relobi_cut_buf #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [2:0]       in_valid,
    output logic [2:0]       in_ready,
    input  logic [Width-1:0] in_data,
    output logic [2:0]       out_valid,
    input  logic [2:0]       out_ready,
    output logic [Width-1:0] out_data,
    output logic             mismatch
);

    logic [1:0]       occ_q [3];
    logic [1:0]       occ_d [3];
    logic [2:0]       wptr_q, wptr_d;
    logic [2:0]       rptr_q, rptr_d;
    logic [2:0]       push, pop;
    logic [1:0]       occ_v;
    logic             wptr_v, rptr_v, push_v;
    logic             waddr, raddr;
    logic [Width-1:0] mem_q [2];

    function automatic logic [1:0] maj2(input logic [1:0] a, input logic [1:0] b,
                                        input logic [1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    // Copy i only ever sees handshake bit i, so a single upset stays local.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            in_ready[i]  = ~rst_i & (occ_q[i] != 2'd2);
            out_valid[i] = ~rst_i & (occ_q[i] != 2'd0);
            push[i]      = in_valid[i] & in_ready[i];
            pop[i]       = out_valid[i] & out_ready[i];
            occ_d[i]     = occ_q[i];
            if (push[i] && !pop[i]) begin
                occ_d[i] = occ_q[i] + 2'd1;
            end else if (pop[i] && !push[i]) begin
                occ_d[i] = occ_q[i] - 2'd1;
            end
            wptr_d[i] = wptr_q[i] ^ push[i];
            rptr_d[i] = rptr_q[i] ^ pop[i];
        end
    end

    assign occ_v  = maj2(occ_d[0], occ_d[1], occ_d[2]);
    assign wptr_v = maj3(wptr_d);
    assign rptr_v = maj3(rptr_d);
    assign push_v = maj3(push);
    assign waddr  = maj3(wptr_q);
    assign raddr  = maj3(rptr_q);

    assign mismatch = (occ_d[0] != occ_d[1]) || (occ_d[1] != occ_d[2]) ||
                      (wptr_d != 3'b000 && wptr_d != 3'b111) ||
                      (rptr_d != 3'b000 && rptr_d != 3'b111);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 3; i++) begin
                occ_q[i] <= 2'd0;
            end
            wptr_q   <= 3'b000;
            rptr_q   <= 3'b000;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                occ_q[i] <= occ_v;
            end
            wptr_q <= {3{wptr_v}};
            rptr_q <= {3{rptr_v}};
            if (push_v) begin
                mem_q[waddr] <= in_data;
            end
        end
    end

    assign out_data = mem_q[raddr];

endmodule

module relobi_cut #(
    parameter int unsigned AChanWidth = 64,
    parameter int unsigned RChanWidth = 48,
    parameter bit          UseRReady  = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [2:0]            sbr_a_req_i,
    output logic [2:0]            sbr_a_gnt_o,
    input  logic [AChanWidth-1:0] sbr_a_i,
    output logic [2:0]            sbr_rvalid_o,
    input  logic [2:0]            sbr_rready_i,
    output logic [RChanWidth-1:0] sbr_r_o,
    output logic [2:0]            mgr_a_req_o,
    input  logic [2:0]            mgr_a_gnt_i,
    output logic [AChanWidth-1:0] mgr_a_o,
    input  logic [2:0]            mgr_rvalid_i,
    output logic [2:0]            mgr_rready_o,
    input  logic [RChanWidth-1:0] mgr_r_i,
    output logic                  fault_o,
    output logic [15:0]           fault_cnt_o
);

    logic [2:0] r_in_ready;
    logic [2:0] r_out_ready;
    logic       a_mismatch, r_mismatch;
    logic       fault_q;

    relobi_cut_buf #(.Width(AChanWidth)) i_a_buf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .in_valid  (sbr_a_req_i),
        .in_ready  (sbr_a_gnt_o),
        .in_data   (sbr_a_i),
        .out_valid (mgr_a_req_o),
        .out_ready (mgr_a_gnt_i),
        .out_data  (mgr_a_o),
        .mismatch  (a_mismatch)
    );

    relobi_cut_buf #(.Width(RChanWidth)) i_r_buf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .in_valid  (mgr_rvalid_i),
        .in_ready  (r_in_ready),
        .in_data   (mgr_r_i),
        .out_valid (sbr_rvalid_o),
        .out_ready (r_out_ready),
        .out_data  (sbr_r_o),
        .mismatch  (r_mismatch)
    );

    // Without R backpressure the buffer drains every cycle, so it never fills.
    if (UseRReady) begin : gen_rready
        assign r_out_ready  = sbr_rready_i;
        assign mgr_rready_o = r_in_ready;
    end else begin : gen_no_rready
        logic unused_rready;
        assign r_out_ready   = 3'b111;
        assign mgr_rready_o  = rst_i ? 3'b000 : 3'b111;
        assign unused_rready = ^{sbr_rready_i, r_in_ready};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= a_mismatch | r_mismatch;
        end
    end

    assign fault_o = fault_q;

`ifdef RELOBI_CUT_FAULT_CNT_EN
    logic [15:0] fault_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fault_cnt_q <= 16'h0000;
        end else if (fault_q && fault_cnt_q != 16'hFFFF) begin
            fault_cnt_q <= fault_cnt_q + 16'd1;
        end
    end

    assign fault_cnt_o = fault_cnt_q;
`else
    assign fault_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_relobi_cut.sv
// Directed bench for relobi_cut: a behavioural queue model predicts every
// handshake, payload and fault output; each cycle is checked on the falling edge.

module tb_relobi_cut;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [2:0]  sbr_a_req_i = '0;
    logic [2:0]  sbr_a_gnt_o;
    logic [63:0] sbr_a_i = '0;
    logic [2:0]  sbr_rvalid_o;
    logic [2:0]  sbr_rready_i = '0;
    logic [47:0] sbr_r_o;
    logic [2:0]  mgr_a_req_o;
    logic [2:0]  mgr_a_gnt_i = '0;
    logic [63:0] mgr_a_o;
    logic [2:0]  mgr_rvalid_i = '0;
    logic [2:0]  mgr_rready_o;
    logic [47:0] mgr_r_i = '0;
    logic        fault_o;
    logic [15:0] fault_cnt_o;

    relobi_cut dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .sbr_a_req_i  (sbr_a_req_i),
        .sbr_a_gnt_o  (sbr_a_gnt_o),
        .sbr_a_i      (sbr_a_i),
        .sbr_rvalid_o (sbr_rvalid_o),
        .sbr_rready_i (sbr_rready_i),
        .sbr_r_o      (sbr_r_o),
        .mgr_a_req_o  (mgr_a_req_o),
        .mgr_a_gnt_i  (mgr_a_gnt_i),
        .mgr_a_o      (mgr_a_o),
        .mgr_rvalid_i (mgr_rvalid_i),
        .mgr_rready_o (mgr_rready_o),
        .mgr_r_i      (mgr_r_i),
        .fault_o      (fault_o),
        .fault_cnt_o  (fault_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    logic [63:0] a_q[$];
    logic [47:0] r_q[$];
    int          a_occ = 0;
    int          r_occ = 0;
    logic        fault_exp = 1'b0;
    logic [15:0] cnt_exp = 16'h0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic maj(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    function automatic logic split(input logic [2:0] v);
        return (v != 3'b000) && (v != 3'b111);
    endfunction

    // Check the state reached after the last rising edge, then drive the next cycle.
    task automatic step(input logic [2:0] a_req, input logic [63:0] a_dat,
                        input logic [2:0] a_gnt, input logic [2:0] r_vld,
                        input logic [47:0] r_dat);
        logic [2:0] a_push, a_pop, r_push;
        logic       a_pu, a_po, r_pu, r_po;
        @(negedge clk_i);
        chk("sbr_a_gnt", 64'(sbr_a_gnt_o), (a_occ != 2) ? 64'h7 : 64'h0);
        chk("mgr_a_req", 64'(mgr_a_req_o), (a_occ != 0) ? 64'h7 : 64'h0);
        if (a_occ != 0) chk("mgr_a_data", mgr_a_o, a_q[0]);
        chk("sbr_rvalid", 64'(sbr_rvalid_o), (r_occ != 0) ? 64'h7 : 64'h0);
        if (r_occ != 0) chk("sbr_r_data", 64'(sbr_r_o), 64'(r_q[0]));
        chk("mgr_rready", 64'(mgr_rready_o), 64'h7);
        chk("fault", 64'(fault_o), 64'(fault_exp));
        chk("fault_cnt", 64'(fault_cnt_o), 64'(cnt_exp));

        sbr_a_req_i  = a_req;
        sbr_a_i      = a_dat;
        mgr_a_gnt_i  = a_gnt;
        mgr_rvalid_i = r_vld;
        mgr_r_i      = r_dat;
        sbr_rready_i = 3'b000;

        a_push = (a_occ != 2) ? a_req : 3'b000;
        a_pop  = (a_occ != 0) ? a_gnt : 3'b000;
        r_push = (r_occ != 2) ? r_vld : 3'b000;
        a_pu = maj(a_push);
        a_po = maj(a_pop);
        r_pu = maj(r_push);
        r_po = (r_occ != 0);
`ifdef RELOBI_CUT_FAULT_CNT_EN
        if (fault_exp && cnt_exp != 16'hFFFF) cnt_exp++;
`endif
        fault_exp = split(a_push) | split(a_pop) | split(r_push);
        if (a_po) begin void'(a_q.pop_front()); a_occ--; end
        if (a_pu) begin a_q.push_back(a_dat); a_occ++; end
        if (r_po) begin void'(r_q.pop_front()); r_occ--; end
        if (r_pu) begin r_q.push_back(r_dat); r_occ++; end
    endtask

    initial begin
        // Held in reset: all handshake outputs low.
        #12;
        chk("rst_sbr_a_gnt", 64'(sbr_a_gnt_o), 64'h0);
        chk("rst_mgr_a_req", 64'(mgr_a_req_o), 64'h0);
        chk("rst_sbr_rvalid", 64'(sbr_rvalid_o), 64'h0);
        chk("rst_mgr_rready", 64'(mgr_rready_o), 64'h0);
        chk("rst_fault", 64'(fault_o), 64'h0);
        chk("rst_fault_cnt", 64'(fault_cnt_o), 64'h0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Single A transfer.
        step(3'b111, 64'hA5, 3'b111, 3'b000, 48'h0);
        step(3'b000, 64'h0, 3'b111, 3'b000, 48'h0);
        step(3'b000, 64'h0, 3'b111, 3'b000, 48'h0);

        // Backpressure: two accepted, third held until the grant returns.
        step(3'b111, 64'h1, 3'b000, 3'b000, 48'h0);
        step(3'b111, 64'h2, 3'b000, 3'b000, 48'h0);
        step(3'b111, 64'h3, 3'b000, 3'b000, 48'h0);
        step(3'b111, 64'h3, 3'b000, 3'b000, 48'h0);
        step(3'b111, 64'h3, 3'b111, 3'b000, 48'h0);
        step(3'b111, 64'h3, 3'b111, 3'b000, 48'h0);
        step(3'b000, 64'h0, 3'b111, 3'b000, 48'h0);
        step(3'b000, 64'h0, 3'b111, 3'b000, 48'h0);

        // Single-copy disagreement on the push is outvoted and flagged.
        step(3'b011, 64'h5A, 3'b000, 3'b000, 48'h0);
        step(3'b000, 64'h0, 3'b000, 3'b000, 48'h0);
        step(3'b000, 64'h0, 3'b111, 3'b000, 48'h0);
        step(3'b000, 64'h0, 3'b000, 3'b000, 48'h0);

        // R streaming without backpressure.
        for (int i = 0; i < 8; i++) begin
            step(3'b000, 64'h0, 3'b000, 3'b111, 48'(i));
        end
        step(3'b000, 64'h0, 3'b000, 3'b000, 48'h0);
        step(3'b000, 64'h0, 3'b000, 3'b000, 48'h0);

        // Mixed traffic including occasional single-bit disagreements.
        for (int i = 0; i < 40; i++) begin
            step(($urandom_range(0, 3) == 0) ? 3'($urandom) : {3{1'($urandom)}},
                 {$urandom, $urandom},
                 ($urandom_range(0, 3) == 0) ? 3'($urandom) : {3{1'($urandom)}},
                 ($urandom_range(0, 3) == 0) ? 3'($urandom) : {3{1'($urandom)}},
                 48'({$urandom, $urandom}));
        end

        // Fill A to two entries, then reset asynchronously mid-cycle.
        step(3'b111, 64'hB1, 3'b000, 3'b000, 48'h0);
        step(3'b111, 64'hB2, 3'b000, 3'b000, 48'h0);
        step(3'b111, 64'hB3, 3'b000, 3'b000, 48'h0);
        step(3'b111, 64'hB3, 3'b000, 3'b000, 48'h0);
        @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        chk("midrst_sbr_a_gnt", 64'(sbr_a_gnt_o), 64'h0);
        chk("midrst_mgr_a_req", 64'(mgr_a_req_o), 64'h0);
        chk("midrst_sbr_rvalid", 64'(sbr_rvalid_o), 64'h0);
        chk("midrst_mgr_rready", 64'(mgr_rready_o), 64'h0);
        chk("midrst_fault", 64'(fault_o), 64'h0);
        @(negedge clk_i);
        rst_i        = 1'b0;
        sbr_a_req_i  = 3'b000;
        mgr_a_gnt_i  = 3'b000;
        mgr_rvalid_i = 3'b000;
        a_q.delete();
        r_q.delete();
        a_occ     = 0;
        r_occ     = 0;
        fault_exp = 1'b0;
        cnt_exp   = 16'h0;
        step(3'b000, 64'h0, 3'b000, 3'b000, 48'h0);
        step(3'b000, 64'h0, 3'b000, 3'b000, 48'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
